sd_bd_fifo: RTL and testbench
=============================

// Module: sd_bd_fifo
// PURPOSE
//  Buffer-descriptor ring for one DMA direction (instantiated once for rx, once for tx).
//  - Sits downstream of the Wishbone register slave and consumes its we_m_*_bd / dat_in_m_*_bd halfword pushes.
//  - Each descriptor is 4 halfwords: addr[15:0], addr[31:16], blk[15:0], blk[31:16].
//  - Stores whole descriptors and hands them, halfword by halfword, to the DMA/data-path side.
//  - Reports free slots for Bd_Status_reg.
// PARAMETERS
//  BD_SIZE   8   descriptor slots; power of two, 2..128
//  BD_AW     3   log2(BD_SIZE); halfword pointers are BD_AW+2 bits wide
// PORTS
//  wb_clk_i    in   1        system clock
//  wb_rst_i    in   1        synchronous active-high reset
//  we_m        in   1        master push strobe, one halfword per cycle high
//  dat_in_m    in   16       master halfword; sampled when we_m=1
//  re_s        in   1        slave pop strobe, one halfword per cycle high
//  dat_out_s   out  16       popped halfword, registered
//  free_bd     out  8        unreserved descriptor slots (0..BD_SIZE)
//  bd_avail    out  1        >=1 complete descriptor or read in progress
//  ovf_o       out  1        1-cycle pulse: descriptor dropped because ring full
//  flush_i     in   1        only with SD_BD_FLUSH_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (wb_rst_i=1 at posedge):
//  - wr_ptr = rd_ptr = 0; wr_phase = rd_phase = 0; used = ready = 0; drop = 0.
//  - Outputs: dat_out_s = 0, free_bd = BD_SIZE, bd_avail = 0, ovf_o = 0.
//  - Storage array is not cleared.
//  - Reset mid-descriptor abandons the partial descriptor with no other effect.
//  Write side (wr_phase 0..3, advances on every we_m, wraps 3->0):
//  - we_m at wr_phase 0 with used<BD_SIZE: accept the descriptor.
//    - used++ (slot reserved); halfword written to mem[wr_ptr]; wr_ptr++.
//  - we_m at wr_phase 0 with used==BD_SIZE: reject the descriptor.
//    - drop=1; ovf_o=1 next cycle; no write.
//  - wr_phase 1..3: write and wr_ptr++ if drop=0; else discard.
//  - wr_phase 3: ready++ if drop=0; drop cleared in either case.
//  - An accepted descriptor always completes; full is tested only at phase 0.
//  Read side (rd_phase 0..3):
//  - re_s at rd_phase 0 with ready==0: ignored; dat_out_s and rd_phase hold.
//  - Otherwise re_s pops:
//    - dat_out_s <= mem[rd_ptr] on the same edge (valid the cycle after re_s; latency 1).
//    - rd_ptr++; rd_phase++.
//    - At rd_phase 0: ready--.
//    - At rd_phase 3: used--.
//  - re_s in rd_phase 1..3 is always honoured.
//  Arithmetic:
//  - Pointers are modulo 4*BD_SIZE and wrap silently.
//  - used and ready are BD_AW+1 bits.
//  - free_bd = BD_SIZE-used, zero-extended to 8 bits, registered (updates 1 cycle after the event).
//  - bd_avail = (ready!=0) | (rd_phase!=0), registered.
//  Simultaneous events:
//  - Phase-0 accept and phase-3 pop in one cycle: used unchanged, free_bd unchanged.
//  - Phase-3 write and phase-0 pop in one cycle: ready unchanged.
//  - Same-cycle write and read of the same address cannot occur (the slot stays reserved until its read completes).
// CONFIGURATION
//  SD_BD_FLUSH_EN defined:
//  - flush_i port exists.
//  - flush_i=1 at a posedge behaves as reset for pointers, phases, used, ready and drop.
//  - dat_out_s holds; free_bd=BD_SIZE and bd_avail=0 next cycle.
//  - flush_i has priority over we_m and re_s in the same cycle.
//  SD_BD_FLUSH_EN undefined:
//  - flush_i port absent.
//  - Ring is cleared only by wb_rst_i.
// TESTING
//  1. Reset, push 1 descriptor 0x1111,0x2222,0x3333,0x4444:
//     - free_bd=7, bd_avail=1.
//     - 4 pops return 0x1111..0x4444, one cycle after each re_s.
//     - Then free_bd=8, bd_avail=0.
//  2. Fill 8 descriptors, push a 9th (0xDEAD x4):
//     - ovf_o pulses once; free_bd stays 0.
//     - Popping all 32 halfwords returns only the first 8 descriptors.
//  3. re_s with ring empty:
//     - dat_out_s unchanged, free_bd=8, no pointer movement.
//     - A later push+pop returns correct data.
//  4. Wrap: 20 descriptors streamed with interleaved pops (ring never full):
//     - All 80 halfwords returned in order across pointer wrap.
//  5. Full ring:
//     - Phase-0 push coincides with phase-3 pop: descriptor accepted, free_bd stays 0, no ovf_o.
//  6. Reset (and flush_i under SD_BD_FLUSH_EN) asserted after 2 halfwords of a descriptor:
//     - free_bd=8, bd_avail=0.
//     - A following complete descriptor reads back intact.

Source files
------------

// File: rtl/sd_bd_fifo_if.sv
// rtl/sd_bd_fifo_if.sv - push/pop bus between the register slave, the descriptor ring and the DMA side
//
// Purpose: bundles the halfword push/pop handshake and the ring status outputs.
// Signals:
//   we_m       push strobe, one halfword per cycle high
//   dat_in_m   pushed halfword, sampled with we_m
//   re_s       pop strobe, one halfword per cycle high
//   dat_out_s  popped halfword, valid the cycle after re_s
//   free_bd    unreserved descriptor slots
//   bd_avail   a complete descriptor is stored or a read is in progress
//   ovf_o      one-cycle pulse when a descriptor is dropped on a full ring
// Modports: master = pusher/popper side, slave = the ring itself.
interface sd_bd_fifo_if;
    logic        we_m;
    logic [15:0] dat_in_m;
    logic        re_s;
    logic [15:0] dat_out_s;
    logic [7:0]  free_bd;
    logic        bd_avail;
    logic        ovf_o;

    modport master (
        output we_m,
        output dat_in_m,
        output re_s,
        input  dat_out_s,
        input  free_bd,
        input  bd_avail,
        input  ovf_o
    );

    modport slave (
        input  we_m,
        input  dat_in_m,
        input  re_s,
        output dat_out_s,
        output free_bd,
        output bd_avail,
        output ovf_o
    );
endinterface

// File: rtl/sd_bd_fifo.sv
// rtl/sd_bd_fifo.sv - buffer-descriptor ring for one DMA direction
//
// Purpose: stores whole 4-halfword descriptors (addr lo, addr hi, blk lo, blk hi)
// pushed by the register slave and hands them halfword by halfword to the DMA side.
// Ports:
//   wb_clk_i   system clock
//   wb_rst_i   synchronous active-high reset
//   flush_i    ring clear, present only when SD_BD_FLUSH_EN is defined
//   bus        sd_bd_fifo_if.slave: we_m/dat_in_m push, re_s/dat_out_s pop,
//              free_bd, bd_avail, ovf_o status
// Parameters:
//   BD_SIZE    descriptor slots, power of two, 2..128
//   BD_AW      log2(BD_SIZE)
// Optional feature: define SD_BD_FLUSH_EN to add the flush_i port.
module sd_bd_fifo #(
    parameter int BD_SIZE = 8,
    parameter int BD_AW   = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
`ifdef SD_BD_FLUSH_EN
    input  logic        flush_i,
`endif
    sd_bd_fifo_if.slave bus
);
    localparam int PW    = BD_AW + 2;
    localparam int UW    = BD_AW + 1;
    localparam int DEPTH = 4 * BD_SIZE;

    localparam logic [UW-1:0] USED_FULL = UW'(BD_SIZE);
    localparam logic [7:0]    FREE_MAX  = 8'(BD_SIZE);

    logic [15:0]   mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    wr_phase;
    logic [1:0]    rd_phase;
    logic [UW-1:0] used;
    logic [UW-1:0] ready;
    logic          drop;

    logic [15:0]   dat_out_q;
    logic [7:0]    free_bd_q;
    logic          bd_avail_q;
    logic          ovf_q;

    // Ring clear request other than reset; tied off when the flush feature is absent.
    logic clr;
`ifdef SD_BD_FLUSH_EN
    assign clr = flush_i;
`else
    assign clr = 1'b0;
`endif

    logic          accept;
    logic          reject;
    logic          wr_en;
    logic          wr_last;
    logic          rd_en;
    logic          rd_first;
    logic          rd_last;
    logic [UW-1:0] used_nxt;
    logic [UW-1:0] ready_nxt;
    logic [1:0]    rd_phase_nxt;

    always_comb begin
        accept       = 1'b0;
        reject       = 1'b0;
        wr_en        = 1'b0;
        wr_last      = 1'b0;
        rd_en        = 1'b0;
        rd_first     = 1'b0;
        rd_last      = 1'b0;
        used_nxt     = used;
        ready_nxt    = ready;
        rd_phase_nxt = rd_phase;

        // A read at phase 0 needs a complete descriptor; mid-descriptor reads always proceed.
        rd_en    = bus.re_s && ((rd_phase != 2'd0) || (ready != '0));
        rd_first = rd_en && (rd_phase == 2'd0);
        rd_last  = rd_en && (rd_phase == 2'd3);

        // Fullness is only judged at the first halfword. A slot released by a
        // read finishing in the same cycle is available to the new descriptor.
        if (bus.we_m && (wr_phase == 2'd0)) begin
            if ((used != USED_FULL) || rd_last) begin
                accept = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end

        wr_en   = accept || (bus.we_m && (wr_phase != 2'd0) && !drop);
        wr_last = bus.we_m && (wr_phase == 2'd3) && !drop;

        if (accept && !rd_last) begin
            used_nxt = used + UW'(1);
        end else if (!accept && rd_last) begin
            used_nxt = used - UW'(1);
        end

        if (wr_last && !rd_first) begin
            ready_nxt = ready + UW'(1);
        end else if (!wr_last && rd_first) begin
            ready_nxt = ready - UW'(1);
        end

        if (rd_en) begin
            rd_phase_nxt = rd_phase + 2'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_phase   <= 2'd0;
            rd_phase   <= 2'd0;
            used       <= '0;
            ready      <= '0;
            drop       <= 1'b0;
            free_bd_q  <= FREE_MAX;
            bd_avail_q <= 1'b0;
            ovf_q      <= 1'b0;
            // A flush keeps the last popped halfword visible; only reset clears it.
            if (wb_rst_i) begin
                dat_out_q <= '0;
            end
        end else begin
            if (bus.we_m) begin
                wr_phase <= wr_phase + 2'd1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // drop marks the remaining halfwords of a rejected descriptor.
            if (reject) begin
                drop <= 1'b1;
            end else if (bus.we_m && (wr_phase == 2'd3)) begin
                drop <= 1'b0;
            end

            if (rd_en) begin
                dat_out_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PW'(1);
            end

            rd_phase   <= rd_phase_nxt;
            used       <= used_nxt;
            ready      <= ready_nxt;
            free_bd_q  <= FREE_MAX - 8'(used_nxt);
            bd_avail_q <= (ready_nxt != '0) || (rd_phase_nxt != 2'd0);
            ovf_q      <= reject;
        end
    end

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en && !wb_rst_i && !clr) begin
            mem[wr_ptr] <= bus.dat_in_m;
        end
    end

    assign bus.dat_out_s = dat_out_q;
    assign bus.free_bd   = free_bd_q;
    assign bus.bd_avail  = bd_avail_q;
    assign bus.ovf_o     = ovf_q;

endmodule

// File: tb/tb_sd_bd_fifo.sv
// tb/tb_sd_bd_fifo.sv - scoreboard testbench for sd_bd_fifo
module tb_sd_bd_fifo;
    localparam int BD_SIZE = 8;

    logic clk = 1'b0;
    logic rst;
`ifdef SD_BD_FLUSH_EN
    logic flush;
`endif

    sd_bd_fifo_if bus ();

    sd_bd_fifo #(
        .BD_SIZE (BD_SIZE),
        .BD_AW   (3)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
`ifdef SD_BD_FLUSH_EN
        .flush_i  (flush),
`endif
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          ovf_seen = 0;
    int          mdl_used = 0;
    logic [15:0] sb [$];
    logic [15:0] last_pop = 16'h0000;
    logic [15:0] exp_hw;

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.ovf_o === 1'b1) ovf_seen++;
    endtask

    task automatic push_desc(input logic [15:0] h0, input logic [15:0] h1,
                             input logic [15:0] h2, input logic [15:0] h3);
        logic [15:0] hw [4];
        hw[0] = h0; hw[1] = h1; hw[2] = h2; hw[3] = h3;
        if (mdl_used < BD_SIZE) begin
            mdl_used++;
            for (int k = 0; k < 4; k++) sb.push_back(hw[k]);
        end
        for (int k = 0; k < 4; k++) begin
            bus.we_m     = 1'b1;
            bus.dat_in_m = hw[k];
            tick();
        end
        bus.we_m = 1'b0;
    endtask

    task automatic pop_hw();
        bus.re_s = 1'b1;
        tick();
        bus.re_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        sb.delete();
        mdl_used = 0;
        n_cmp++; if (bus.dat_out_s !== 16'h0000) begin n_bad++; $display("FAIL rst_dat: got %h want 0000", bus.dat_out_s); end
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL rst_free: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL rst_avail: got %b want 0", bus.bd_avail); end
        n_cmp++; if (bus.ovf_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.ovf_o); end
    endtask

    task automatic test_single();
        push_desc(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        tick();
        n_cmp++; if (bus.free_bd !== 8'd7) begin n_bad++; $display("FAIL single_free: got %0d want 7", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b1) begin n_bad++; $display("FAIL single_avail: got %b want 1", bus.bd_avail); end
        for (int k = 0; k < 4; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL single_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used--;
        tick();
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL single_free_end: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL single_avail_end: got %b want 0", bus.bd_avail); end
    endtask

    task automatic test_overflow();
        int ovf0;
        for (int i = 0; i < BD_SIZE; i++)
            push_desc(16'(16'h2000 + i * 16), 16'(16'h2001 + i * 16),
                      16'(16'h2002 + i * 16), 16'(16'h2003 + i * 16));
        tick();
        n_cmp++; if (bus.free_bd !== 8'd0) begin n_bad++; $display("FAIL ovf_full_free: got %0d want 0", bus.free_bd); end
        ovf0 = ovf_seen;
        push_desc(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
        tick();
        tick();
        n_cmp++; if (ovf_seen - ovf0 !== 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 1", ovf_seen - ovf0); end
        n_cmp++; if (bus.free_bd !== 8'd0) begin n_bad++; $display("FAIL ovf_free_after: got %0d want 0", bus.free_bd); end
        for (int k = 0; k < 4 * BD_SIZE; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL ovf_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used = 0;
        tick();
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL ovf_drain_free: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL ovf_drain_avail: got %b want 0", bus.bd_avail); end
    endtask

    task automatic test_empty_read();
        for (int k = 0; k < 3; k++) pop_hw();
        tick();
        n_cmp++; if (bus.dat_out_s !== last_pop) begin n_bad++; $display("FAIL empty_dat_hold: got %h want %h", bus.dat_out_s, last_pop); end
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL empty_free: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL empty_avail: got %b want 0", bus.bd_avail); end
        push_desc(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        for (int k = 0; k < 4; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL empty_then_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used--;
    endtask

    task automatic test_wrap();
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            push_desc(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            if (i >= 2) begin
                for (int k = 0; k < 4; k++) begin
                    pop_hw();
                    exp_hw = sb.pop_front(); last_pop = exp_hw;
                    n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL wrap_pop[%0d]: got %h want %h", n, bus.dat_out_s, exp_hw); end
                    n++;
                end
                mdl_used--;
            end
        end
        while (sb.size() != 0) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL wrap_drain[%0d]: got %h want %h", n, bus.dat_out_s, exp_hw); end
            n++;
        end
        mdl_used = 0;
    endtask

    task automatic test_full_concurrent();
        int ovf0;
        logic [15:0] nd [4];
        for (int i = 0; i < BD_SIZE; i++)
            push_desc(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        tick();
        for (int k = 0; k < 3; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL conc_pre_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        for (int k = 0; k < 4; k++) nd[k] = 16'($urandom);
        ovf0 = ovf_seen;
        // Last halfword of the oldest descriptor leaves as the new one starts.
        bus.re_s     = 1'b1;
        bus.we_m     = 1'b1;
        bus.dat_in_m = nd[0];
        tick();
        bus.re_s = 1'b0;
        exp_hw = sb.pop_front(); last_pop = exp_hw;
        n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL conc_pop: got %h want %h", bus.dat_out_s, exp_hw); end
        for (int k = 0; k < 4; k++) sb.push_back(nd[k]);
        for (int k = 1; k < 4; k++) begin
            bus.we_m     = 1'b1;
            bus.dat_in_m = nd[k];
            tick();
        end
        bus.we_m = 1'b0;
        tick();
        n_cmp++; if (bus.free_bd !== 8'd0) begin n_bad++; $display("FAIL conc_free: got %0d want 0", bus.free_bd); end
        n_cmp++; if (ovf_seen !== ovf0) begin n_bad++; $display("FAIL conc_ovf: got %0d pulses want 0", ovf_seen - ovf0); end
        for (int k = 0; k < 4 * BD_SIZE; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL conc_drain[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used = 0;
        tick();
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL conc_free_end: got %0d want 8", bus.free_bd); end
    endtask

    task automatic test_reset_mid();
        bus.we_m = 1'b1; bus.dat_in_m = 16'hAAAA; tick();
        bus.dat_in_m = 16'hBBBB; tick();
        bus.we_m = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL rmid_free: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL rmid_avail: got %b want 0", bus.bd_avail); end
        push_desc(16'h9999, 16'hA0A0, 16'hB1B1, 16'hC2C2);
        for (int k = 0; k < 4; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL rmid_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used--;
`ifdef SD_BD_FLUSH_EN
        bus.we_m = 1'b1; bus.dat_in_m = 16'hEEEE; tick();
        bus.dat_in_m = 16'hFFFF; tick();
        bus.we_m = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0; tick();
        n_cmp++; if (bus.free_bd !== 8'd8) begin n_bad++; $display("FAIL fmid_free: got %0d want 8", bus.free_bd); end
        n_cmp++; if (bus.bd_avail !== 1'b0) begin n_bad++; $display("FAIL fmid_avail: got %b want 0", bus.bd_avail); end
        n_cmp++; if (bus.dat_out_s !== last_pop) begin n_bad++; $display("FAIL fmid_dat_hold: got %h want %h", bus.dat_out_s, last_pop); end
        push_desc(16'h1357, 16'h2468, 16'h3579, 16'h468A);
        for (int k = 0; k < 4; k++) begin
            pop_hw();
            exp_hw = sb.pop_front(); last_pop = exp_hw;
            n_cmp++; if (bus.dat_out_s !== exp_hw) begin n_bad++; $display("FAIL fmid_pop[%0d]: got %h want %h", k, bus.dat_out_s, exp_hw); end
        end
        mdl_used--;
`endif
    endtask

    initial begin
        rst          = 1'b1;
`ifdef SD_BD_FLUSH_EN
        flush        = 1'b0;
`endif
        bus.we_m     = 1'b0;
        bus.dat_in_m = 16'h0000;
        bus.re_s     = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_empty_read();
        test_wrap();
        test_full_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
